// File: rtl/spindle_pkg.sv
// Shared state type, state code width and sizing helper for the spindle drive sequencer.
package spindle_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    STAR  = 3'd1,
    DEAD  = 3'd2,
    DELTA = 3'd3,
    BRAKE = 3'd4,
    FAULT = 3'd5
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycle counter with synchronous clear; done is high on the cycle count == limit-1.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done = en && (count == limit - W'(1));

endmodule

// File: rtl/spindle_drive_seq.sv
// Star-delta spindle contactor sequencer with timed brake, e-stop and latched fault.
// Define SPINDLE_FB_CHECK_EN to enable main-contactor feedback supervision.
module spindle_drive_seq
  import spindle_pkg::*;
#(
  parameter int STAR_CYCLES       = 100_000_000,
  parameter int DEADTIME_CYCLES   = 2_500_000,
  parameter int BRAKE_CYCLES      = 50_000_000,
  parameter int FB_TIMEOUT_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               control,
  input  logic               fb_main,
  input  logic               estop,
  input  logic               fault_clr,
  output logic               k_main,
  output logic               k_star,
  output logic               k_delta,
  output logic               brake,
  output logic               running,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);

  localparam int MAX_CNT = max_of(max_of(STAR_CYCLES, DEADTIME_CYCLES),
                                  max_of(BRAKE_CYCLES, FB_TIMEOUT_CYCLES));
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  state_t           state, next_state;
  logic             ph_done, ph_en, fb_fault;
  logic [CNT_W-1:0] ph_limit;
  logic             main_d, star_d, delta_d, brake_d, running_d, fault_d;

  always_comb begin
    ph_en    = 1'b1;
    ph_limit = CNT_W'(STAR_CYCLES);
    case (state)
      STAR:    ph_limit = CNT_W'(STAR_CYCLES);
      DEAD:    ph_limit = CNT_W'(DEADTIME_CYCLES);
      BRAKE:   ph_limit = CNT_W'(BRAKE_CYCLES);
      default: ph_en    = 1'b0;
    endcase
  end

  phase_timer #(.W(CNT_W)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (next_state != state),
    .en    (ph_en),
    .limit (ph_limit),
    .done  (ph_done)
  );

`ifdef SPINDLE_FB_CHECK_EN
  logic fb_seen, wd_done, star_entry, fb_active;

  assign fb_active  = (state == STAR) || (state == DEAD) || (state == DELTA);
  assign star_entry = (state != STAR) && (next_state == STAR);

  phase_timer #(.W(CNT_W)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (star_entry),
    .en    (state == STAR),
    .limit (CNT_W'(FB_TIMEOUT_CYCLES)),
    .done  (wd_done)
  );

  always_ff @(posedge clk) begin
    if (rst || star_entry) begin
      fb_seen <= 1'b0;
    end else if (fb_active && fb_main) begin
      fb_seen <= 1'b1;
    end
  end

  // Low feedback is a fault once it has been seen, or at watchdog expiry if never seen.
  assign fb_fault = fb_active && !fb_main && (fb_seen || ((state == STAR) && wd_done));
`else
  logic unused_fb;
  assign unused_fb = fb_main;
  assign fb_fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k_main  <= 1'b0;
      k_star  <= 1'b0;
      k_delta <= 1'b0;
      brake   <= 1'b0;
      running <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= next_state;
      k_main  <= main_d;
      k_star  <= star_d;
      k_delta <= delta_d;
      brake   <= brake_d;
      running <= running_d;
      fault   <= fault_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (estop)        next_state = FAULT;
        else if (control) next_state = STAR;
      end
      STAR: begin
        if (estop || fb_fault) next_state = FAULT;
        else if (!control)     next_state = BRAKE;
        else if (ph_done)      next_state = DEAD;
      end
      DEAD: begin
        if (estop || fb_fault) next_state = FAULT;
        else if (!control)     next_state = BRAKE;
        else if (ph_done)      next_state = DELTA;
      end
      DELTA: begin
        if (estop || fb_fault) next_state = FAULT;
        else if (!control)     next_state = BRAKE;
      end
      BRAKE: begin
        if (estop)        next_state = FAULT;
        else if (ph_done) next_state = IDLE;
      end
      FAULT: begin
        if (fault_clr && !control && !estop) next_state = IDLE;
      end
      default: next_state = FAULT;
    endcase
  end

  // Outputs decode the upcoming state so the registers match the state from its first cycle.
  always_comb begin
    main_d    = 1'b0;
    star_d    = 1'b0;
    delta_d   = 1'b0;
    brake_d   = 1'b0;
    running_d = 1'b0;
    fault_d   = 1'b0;
    case (next_state)
      STAR:  begin main_d = 1'b1; star_d = 1'b1; end
      DEAD:  main_d = 1'b1;
      DELTA: begin main_d = 1'b1; delta_d = 1'b1; running_d = 1'b1; end
      BRAKE: brake_d = 1'b1;
      FAULT: begin brake_d = 1'b1; fault_d = 1'b1; end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_spindle_drive_seq.sv
// Table-driven, scoreboarded bench for spindle_drive_seq; expectations follow SPINDLE_FB_CHECK_EN.
module tb_spindle_drive_seq;
  import spindle_pkg::*;

  logic clk = 1'b0;
  logic rst, control, fb_main, estop, fault_clr;
  logic k_main, k_star, k_delta, brake, running, fault;
  logic [STATE_W-1:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic   r, c, f, e, k;
    int     n;
    state_t exp;
  } vec_t;

  vec_t   vecs[$];
  state_t sb[$];

  spindle_drive_seq #(
    .STAR_CYCLES       (10),
    .DEADTIME_CYCLES   (3),
    .BRAKE_CYCLES      (5),
    .FB_TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .control   (control),
    .fb_main   (fb_main),
    .estop     (estop),
    .fault_clr (fault_clr),
    .k_main    (k_main),
    .k_star    (k_star),
    .k_delta   (k_delta),
    .brake     (brake),
    .running   (running),
    .fault     (fault),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // {state, k_main, k_star, k_delta, brake, running, fault}
  function automatic logic [8:0] model(input state_t s);
    case (s)
      IDLE:    return {3'd0, 6'b000000};
      STAR:    return {3'd1, 6'b110000};
      DEAD:    return {3'd2, 6'b100000};
      DELTA:   return {3'd3, 6'b101010};
      BRAKE:   return {3'd4, 6'b000100};
      FAULT:   return {3'd5, 6'b000101};
      default: return 9'h1ff;
    endcase
  endfunction

  task automatic add(input logic r, c, f, e, k, input int n, input state_t exp);
    vec_t v;
    v.r = r; v.c = c; v.f = f; v.e = e; v.k = k; v.n = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, c, f, e, k, input state_t exp, input string tag);
    state_t     want;
    logic [8:0] got, req;
    rst = r; control = c; fb_main = f; estop = e; fault_clr = k;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    req  = model(want);
    got  = {state_o, k_main, k_star, k_delta, brake, running, fault};
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got state=%0d outs=%b, required state=%0d outs=%b",
               tag, got[8:6], got[5:0], req[8:6], req[5:0]);
    end
    compared++;
    if (k_star && k_delta) begin
      mismatched++;
      $display("FAIL %s overlap: k_star=%b k_delta=%b, required not both 1", tag, k_star, k_delta);
    end
  endtask

  initial begin
    rst = 1'b1; control = 1'b0; fb_main = 1'b0; estop = 1'b0; fault_clr = 1'b0;

    // Reset, normal start, stop with ignored restart request, restart.
    add(1, 0, 0, 0, 0, 2, IDLE);
    add(0, 0, 0, 0, 0, 2, IDLE);
    add(0, 1, 0, 0, 0, 2, STAR);
    add(0, 1, 1, 0, 0, 8, STAR);
    add(0, 1, 1, 0, 0, 3, DEAD);
    add(0, 1, 1, 0, 0, 4, DELTA);
    add(0, 0, 1, 0, 0, 1, BRAKE);
    add(0, 1, 1, 0, 0, 4, BRAKE);
    add(0, 1, 1, 0, 0, 1, IDLE);
    add(0, 1, 1, 0, 0, 10, STAR);
    add(0, 1, 1, 0, 0, 3, DEAD);
    add(0, 1, 1, 0, 0, 2, DELTA);
`ifdef SPINDLE_FB_CHECK_EN
    // Feedback loss in DELTA, then clear attempts.
    add(0, 1, 0, 0, 0, 1, FAULT);
    add(0, 1, 0, 0, 1, 2, FAULT);
    add(0, 0, 0, 0, 1, 1, IDLE);
    // Feedback never seen: watchdog fires on the 4th STAR cycle.
    add(0, 1, 0, 0, 0, 4, STAR);
    add(0, 1, 0, 0, 0, 1, FAULT);
    add(0, 1, 0, 0, 1, 1, FAULT);
    add(0, 0, 0, 0, 1, 1, IDLE);
`else
    add(0, 1, 0, 0, 0, 3, DELTA);
    add(0, 0, 0, 0, 0, 5, BRAKE);
    add(0, 0, 0, 0, 0, 1, IDLE);
    add(0, 1, 0, 0, 0, 10, STAR);
    add(0, 1, 0, 0, 0, 3, DEAD);
    add(0, 0, 0, 0, 0, 5, BRAKE);
    add(0, 0, 0, 0, 0, 1, IDLE);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        step(vecs[i].r, vecs[i].c, vecs[i].f, vecs[i].e, vecs[i].k, vecs[i].exp,
             $sformatf("vec%0d.%0d", i, j));
      end
    end

    // E-stop in DEAD beats the same-cycle stop request, then reset.
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, STAR, "es_star");
    for (int i = 0; i < 2; i++)  step(0, 1, 1, 0, 0, DEAD, "es_dead");
    step(0, 0, 1, 1, 0, FAULT, "es_enter");
    step(0, 0, 1, 1, 1, FAULT, "es_clr_held");
    step(0, 0, 1, 0, 0, FAULT, "es_latched");
    step(1, 1, 1, 0, 0, IDLE,  "es_rst");
    step(0, 0, 0, 0, 0, IDLE,  "es_idle");

    // E-stop wins over a start request in IDLE.
    step(0, 1, 1, 1, 0, FAULT, "idle_estop");
    step(0, 0, 1, 0, 1, IDLE,  "idle_clr");

    // Reset mid-STAR.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, STAR, "mid_star");
    step(1, 1, 1, 0, 0, IDLE, "mid_rst");
    step(0, 0, 0, 0, 0, IDLE, "mid_idle");

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
